// File: rtl/rgb_fade_ctrl_if.sv
// rgb_fade_ctrl_if: bundles the fade sequencer's control and level signals.
// The master side supplies load and targets.
// The slave side is the fade controller, which returns levels, busy and done.
interface rgb_fade_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             load;
  logic [WIDTH-1:0] target0;
  logic [WIDTH-1:0] target1;
  logic [WIDTH-1:0] target2;
  logic [WIDTH-1:0] level0;
  logic [WIDTH-1:0] level1;
  logic [WIDTH-1:0] level2;
  logic             busy;
  logic             done;

  modport master (
    output load, target0, target1, target2,
    input  level0, level1, level2, busy, done
  );

  modport slave (
    input  load, target0, target1, target2,
    output level0, level1, level2, busy, done
  );
endinterface

// File: rtl/rgb_fade_ctrl.sv
// rgb_fade_ctrl: fade sequencer between the encoder targets and the three PWM channels.
// Each channel level walks one LSB per prescaler tick towards its captured target.
// busy is high while fading, and done pulses once when all channels have arrived.
// Optional feature macro GAMMA_EN adds a registered square-law output mapping.
// That mapping delays busy and done by one cycle so they stay aligned with the outputs.
module rgb_fade_ctrl #(
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 256
) (
  input  logic             clk,
  input  logic             reset,
  rgb_fade_ctrl_if.slave   bus
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] FADE = 1'b1;

  logic [0:0]            state_d, state_q;
  logic [2:0][WIDTH-1:0] tgt_d, tgt_q;
  logic [2:0][WIDTH-1:0] lvl_d, lvl_q;
  logic [PW-1:0]         presc_d, presc_q;
  logic                  busy_d, busy_q;
  logic                  done_d, done_q;

  function automatic logic [WIDTH-1:0] step_towards(input logic [WIDTH-1:0] lvl,
                                                    input logic [WIDTH-1:0] tgt);
    if (lvl < tgt)      return lvl + 1'b1;
    else if (lvl > tgt) return lvl - 1'b1;
    else                return lvl;
  endfunction

  // Next-state logic: capture or retarget on load, finish on equality, otherwise step on tick
  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    lvl_d   = lvl_q;
    presc_d = presc_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        presc_d = '0;
        if (bus.load) begin
          tgt_d   = {bus.target2, bus.target1, bus.target0};
          state_d = FADE;
        end
      end
      FADE: begin
        if (bus.load) begin
          tgt_d   = {bus.target2, bus.target1, bus.target0};
          presc_d = (presc_q == PRE_MAX) ? '0 : presc_q + 1'b1;
        end else if (lvl_q == tgt_q) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (presc_q == PRE_MAX) begin
          for (int i = 0; i < 3; i++) lvl_d[i] = step_towards(lvl_q[i], tgt_q[i]);
          presc_d = '0;
        end else begin
          presc_d = presc_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == FADE);
  end

  // Core registers, synchronous reset overriding everything including a pending load
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      tgt_q   <= '0;
      lvl_q   <= '0;
      presc_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      lvl_q   <= lvl_d;
      presc_q <= presc_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

`ifdef GAMMA_EN
  logic [2:0][2*WIDTH-1:0] sq;
  logic [2:0][WIDTH-1:0]   gam_d, gam_q;
  logic                    busy_out_d, busy_out_q;
  logic                    done_out_d, done_out_q;

  // Square-law mapping with round-up bias so 0, 1 and full scale map to themselves
  always_comb begin
    sq         = '0;
    gam_d      = '0;
    busy_out_d = busy_q;
    done_out_d = done_q;
    for (int i = 0; i < 3; i++) begin
      sq[i]    = ({{WIDTH{1'b0}}, lvl_q[i]} * {{WIDTH{1'b0}}, lvl_q[i]})
                 + {{WIDTH{1'b0}}, {WIDTH{1'b1}}};
      gam_d[i] = sq[i][2*WIDTH-1:WIDTH];
    end
  end

  // Output stage: mapped levels plus status delayed to match them
  always_ff @(posedge clk) begin
    if (reset) begin
      gam_q      <= '0;
      busy_out_q <= 1'b0;
      done_out_q <= 1'b0;
    end else begin
      gam_q      <= gam_d;
      busy_out_q <= busy_out_d;
      done_out_q <= done_out_d;
    end
  end

  assign bus.level0 = gam_q[0];
  assign bus.level1 = gam_q[1];
  assign bus.level2 = gam_q[2];
  assign bus.busy   = busy_out_q;
  assign bus.done   = done_out_q;
`else
  assign bus.level0 = lvl_q[0];
  assign bus.level1 = lvl_q[1];
  assign bus.level2 = lvl_q[2];
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
`endif

endmodule

// File: tb/tb_rgb_fade_ctrl.sv
// tb_rgb_fade_ctrl: table-driven bench for rgb_fade_ctrl with WIDTH=8 and PRESCALE=4.
// Each load pushes its expected final levels and done latency onto a scoreboard.
// Latency is counted in edges from the last load edge until done is sampled high.
module tb_rgb_fade_ctrl;
  localparam int WIDTH    = 8;
  localparam int PRESCALE = 4;
  localparam int LIMIT    = 3000;
`ifdef GAMMA_EN
  localparam int LAT_ADJ = 1;
`else
  localparam int LAT_ADJ = 0;
`endif

  typedef struct {
    string name;
    int    l0, l1, l2;
    int    latency;
  } exp_t;

  typedef struct {
    string      name;
    logic [7:0] t0, t1, t2;
    int         e0, e1, e2;
    int         lat;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   num_vectors = 0;
  int   num_miscompares = 0;
  exp_t sb_q[$];
  vec_t vecs[5];

  rgb_fade_ctrl_if #(.WIDTH(WIDTH)) bus ();

  rgb_fade_ctrl #(.WIDTH(WIDTH), .PRESCALE(PRESCALE)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic int out_of(input int lin);
`ifdef GAMMA_EN
    return (lin * lin + 255) >> 8;
`else
    return lin;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string name, input int actual, input int expected);
    num_vectors++;
    if (actual != expected) begin
      num_miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Drive targets, hold load for 'hold' edges, and push the expected outcome
  task automatic apply_stimulus(input exp_t e, input logic [7:0] t0, input logic [7:0] t1,
                                input logic [7:0] t2, input int hold);
    int l0, l1, l2, bad;
    l0 = int'(bus.level0);
    l1 = int'(bus.level1);
    l2 = int'(bus.level2);
    bad = 0;
    bus.target0 = t0;
    bus.target1 = t1;
    bus.target2 = t2;
    bus.load    = 1'b1;
    sb_q.push_back(e);
    for (int i = 0; i < hold; i++) begin
      tick();
      if (bus.done || int'(bus.level0) != l0 || int'(bus.level1) != l1 ||
          int'(bus.level2) != l2)
        bad++;
    end
    bus.load = 1'b0;
    check_output({e.name, "_frozen_during_load"}, bad, 0);
  endtask

  // Wait for done, then pop and compare latency, levels, busy span and pulse width
  task automatic run_and_score(output int min0, output int max0);
    int   n, busy_cnt, lv;
    bit   seen;
    exp_t e;
    n = 0;
    busy_cnt = 0;
    seen = 1'b0;
    min0 = 1 << 30;
    max0 = -1;
    while (!seen && n < LIMIT) begin
      tick();
      n++;
      lv = int'(bus.level0);
      if (lv < min0) min0 = lv;
      if (lv > max0) max0 = lv;
      if (bus.done) seen = 1'b1;
      else if (bus.busy) busy_cnt++;
    end
    if (sb_q.size() == 0) begin
      check_output("scoreboard_empty", 1, 0);
      return;
    end
    e = sb_q.pop_front();
    check_output({e.name, "_latency"}, n, e.latency);
    check_output({e.name, "_level0"}, int'(bus.level0), e.l0);
    check_output({e.name, "_level1"}, int'(bus.level1), e.l1);
    check_output({e.name, "_level2"}, int'(bus.level2), e.l2);
    check_output({e.name, "_busy_cycles"}, busy_cnt, e.latency - 1);
    check_output({e.name, "_busy_at_done"}, int'(bus.busy), 0);
    tick();
    check_output({e.name, "_done_one_cycle"}, int'(bus.done), 0);
  endtask

  initial begin
    exp_t e;
    int   mn, mx, early_done, found;

    vecs[0] = '{"up_mixed",    8'd255, 8'd0,   8'd128, 255, 0,   128, 1021};
    vecs[1] = '{"to_200",      8'd200, 8'd200, 8'd200, 200, 200, 200, 801};
    vecs[2] = '{"down_up_hold",8'd10,  8'd200, 8'd255, 10,  200, 255, 761};
    vecs[3] = '{"equal",       8'd10,  8'd200, 8'd255, 10,  200, 255, 1};
    vecs[4] = '{"to_zero",     8'd0,   8'd0,   8'd0,   0,   0,   0,   1021};

    reset = 1'b1;
    bus.load = 1'b0;
    bus.target0 = '0;
    bus.target1 = '0;
    bus.target2 = '0;
    repeat (3) tick();
    check_output("reset_level0", int'(bus.level0), 0);
    check_output("reset_level1", int'(bus.level1), 0);
    check_output("reset_level2", int'(bus.level2), 0);
    check_output("reset_busy", int'(bus.busy), 0);
    check_output("reset_done", int'(bus.done), 0);
    reset = 1'b0;
    tick();

    // Reset mid-fade, with load asserted on the reset edge
    bus.target0 = 8'd255;
    bus.target1 = 8'd255;
    bus.target2 = 8'd255;
    bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
    repeat (50) tick();
    check_output("midfade_busy", int'(bus.busy), 1);
    reset = 1'b1;
    bus.load = 1'b1;
    bus.target0 = 8'd77;
    tick();
    check_output("midreset_level0", int'(bus.level0), 0);
    check_output("midreset_level2", int'(bus.level2), 0);
    check_output("midreset_busy", int'(bus.busy), 0);
    check_output("midreset_done", int'(bus.done), 0);
    reset = 1'b0;
    bus.load = 1'b0;
    repeat (5) tick();
    check_output("reset_load_ignored_busy", int'(bus.busy), 0);
    check_output("reset_load_ignored_level0", int'(bus.level0), 0);

    // Table-driven fades, each starting from the previous end levels
    for (int i = 0; i < 5; i++) begin
      e = '{vecs[i].name, out_of(vecs[i].e0), out_of(vecs[i].e1), out_of(vecs[i].e2),
            vecs[i].lat + LAT_ADJ};
      apply_stimulus(e, vecs[i].t0, vecs[i].t1, vecs[i].t2, 1);
      run_and_score(mn, mx);
    end

    // Load held for 41 edges: levels frozen, prescaler phase ends back at zero
    e = '{"held_load", out_of(20), out_of(20), out_of(20), 81 + LAT_ADJ};
    apply_stimulus(e, 8'd20, 8'd20, 8'd20, 41);
    run_and_score(mn, mx);

    // Retarget downwards mid-fade
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    bus.target0 = 8'd255;
    bus.target1 = 8'd0;
    bus.target2 = 8'd0;
    bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
    early_done = 0;
    found = 0;
    for (int i = 0; i < 1000 && found == 0; i++) begin
      tick();
      if (bus.done) early_done++;
      if (int'(bus.level0) == out_of(100)) found = 1;
    end
    check_output("retarget_reached_100", found, 1);
    check_output("retarget_early_done", early_done, 0);
    e = '{"retarget", out_of(50), 0, 0, 200};
    apply_stimulus(e, 8'd50, 8'd0, 8'd0, 1);
    run_and_score(mn, mx);
    check_output("retarget_min_level0", mn, out_of(50));
    check_output("retarget_max_level0", mx, out_of(100));

    check_output("scoreboard_drained", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", num_vectors, num_miscompares);
    $finish;
  end
endmodule
